// File: rtl/result_hex_streamer.sv
// result_hex_streamer
// Takes one result word per in_valid/in_ready handshake and emits it as ASCII
// hex, most significant nibble first, one byte per out_valid/out_ready
// transfer, optionally terminated by a newline (0x0A).
// Optional build feature: define HEX_PREFIX_EN to precede the digits with "0x".
// All outputs are decoded from registered state only.
module result_hex_streamer #(
  parameter int DATA_W       = 64,
  parameter int UPPERCASE    = 0,
  parameter int EMIT_NEWLINE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int NDIG  = DATA_W / 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIGIT = 2'd1;
  localparam logic [1:0] S_TERM  = 2'd2;
`ifdef HEX_PREFIX_EN
  localparam logic [1:0] S_PREFIX = 2'd3;
`endif

  logic [1:0]        state_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [DATA_W-1:0] shadow_p0;
  logic              up_p0;      // low until the first edge after reset release
`ifdef HEX_PREFIX_EN
  logic              pfx_p0;     // 0 -> emitting '0', 1 -> emitting 'x'
`endif

  logic       xfer;
  logic       accept;
  logic [3:0] nib;

  // Map one nibble to its ASCII hex digit in the configured letter case.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPERCASE != 0)
      return 8'h41 + ({4'h0, n} - 8'd10);
    else
      return 8'h61 + ({4'h0, n} - 8'd10);
  endfunction

  assign xfer     = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign nib      = shadow_p0[DATA_W-1-4*idx_p0 -: 4];
  assign in_ready = up_p0 && (state_p0 == S_IDLE);
  assign busy     = (state_p0 != S_IDLE);

  // Control FSM, digit index and captured word; only a completed transfer advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0  <= S_IDLE;
      idx_p0    <= '0;
      shadow_p0 <= '0;
      up_p0     <= 1'b0;
`ifdef HEX_PREFIX_EN
      pfx_p0    <= 1'b0;
`endif
    end else begin
      up_p0 <= 1'b1;
      case (state_p0)
        S_IDLE: begin
          if (accept) begin
            shadow_p0 <= in_data;
            idx_p0    <= '0;
`ifdef HEX_PREFIX_EN
            pfx_p0    <= 1'b0;
            state_p0  <= S_PREFIX;
`else
            state_p0  <= S_DIGIT;
`endif
          end
        end
`ifdef HEX_PREFIX_EN
        S_PREFIX: begin
          if (xfer) begin
            if (pfx_p0) state_p0 <= S_DIGIT;
            else        pfx_p0   <= 1'b1;
          end
        end
`endif
        S_DIGIT: begin
          if (xfer) begin
            if (idx_p0 == IDX_LAST)
              state_p0 <= (EMIT_NEWLINE != 0) ? S_TERM : S_IDLE;
            else
              idx_p0 <= idx_p0 + 1'b1;
          end
        end
        S_TERM: begin
          if (xfer) state_p0 <= S_IDLE;
        end
        default: state_p0 <= S_IDLE;
      endcase
    end
  end

  // Output byte, valid and last flag decoded from the registered state.
  always_comb begin
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state_p0)
`ifdef HEX_PREFIX_EN
      S_PREFIX: begin
        out_valid = 1'b1;
        out_char  = pfx_p0 ? 8'h78 : 8'h30;
      end
`endif
      S_DIGIT: begin
        out_valid = 1'b1;
        out_char  = hex_ascii(nib);
        out_last  = (EMIT_NEWLINE == 0) && (idx_p0 == IDX_LAST);
      end
      S_TERM: begin
        out_valid = 1'b1;
        out_char  = 8'h0A;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_hex_streamer.sv
// Directed bench for result_hex_streamer: a default instance (lowercase,
// newline) and an UPPERCASE=1, EMIT_NEWLINE=0 instance. Expected byte streams
// are written out as literal strings.
module tb_result_hex_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv0, ir0, ov0, or0, ol0, bz0;
  logic [63:0] id0;
  logic [7:0]  oc0;
  logic        iv1, ir1, ov1, or1, ol1, bz1;
  logic [63:0] id1;
  logic [7:0]  oc1;

  int total = 0;
  int bad   = 0;

  result_hex_streamer dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_char(oc0), .out_last(ol0),
    .busy(bz0)
  );

  result_hex_streamer #(.DATA_W(64), .UPPERCASE(1), .EMIT_NEWLINE(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_char(oc1), .out_last(ol1),
    .busy(bz1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string pfx();
`ifdef HEX_PREFIX_EN
    return "0x";
`else
    return "";
`endif
  endfunction

  task automatic send(input int w, input logic [63:0] d);
    int n;
    n = 0;
    while (!((w == 0) ? ir0 : ir1) && n < 40) begin
      step();
      n++;
    end
    chk("send_ready", (w == 0) ? ir0 : ir1, 1);
    if (w == 0) begin iv0 = 1'b1; id0 = d; end
    else        begin iv1 = 1'b1; id1 = d; end
    step();
    if (w == 0) iv0 = 1'b0;
    else        iv1 = 1'b0;
  endtask

  task automatic recv(input int w, input string s, input int from, input int upto);
    int n;
    for (int k = from; k < upto; k++) begin
      n = 0;
      while (!((w == 0) ? ov0 : ov1) && n < 40) begin
        step();
        n++;
      end
      chk($sformatf("w%0d_valid%0d", w, k), (w == 0) ? ov0 : ov1, 1);
      chk($sformatf("w%0d_char%0d", w, k), (w == 0) ? oc0 : oc1, s[k]);
      chk($sformatf("w%0d_last%0d", w, k), (w == 0) ? ol0 : ol1, (k == s.len() - 1));
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s0, s1, sb;
    int    p;
    p  = pfx().len();
    s0 = {pfx(), "0123456789abcdef\n"};
    s1 = {pfx(), "FEDCBA9876543210"};
    sb = {pfx(), "00000000deadbeef\n"};

    rst_n = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; id0 = '0; id1 = '0; or0 = 1'b1; or1 = 1'b1;

    // Reset state
    step(); step(); step();
    chk("rst_in_ready", ir0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_char", oc0, 8'h00);
    chk("rst_out_last", ol0, 0);
    chk("rst_busy", bz0, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", ir0, 0);
    step();
    chk("rdy_after_edge", ir0, 1);
    chk("rdy_after_edge_u", ir1, 1);

    // Full word, lowercase with newline
    send(0, 64'h0123456789abcdef);
    chk("busy_first", bz0, 1);
    chk("ready_first", ir0, 0);
    recv(0, s0, 0, s0.len());
    chk("busy_after", bz0, 0);
    chk("ready_after", ir0, 1);
    chk("valid_after", ov0, 0);

    // Uppercase, no newline: last flag on the final digit
    send(1, 64'hFEDCBA9876543210);
    recv(1, s1, 0, s1.len());
    chk("u_busy_after", bz1, 0);
    chk("u_valid_after", ov1, 0);

    // Backpressure on the 6th digit
    send(0, 64'h0123456789abcdef);
    recv(0, s0, 0, p + 5);
    or0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", ov0, 1);
      chk("bp_char", oc0, 8'h35);
      chk("bp_last", ol0, 0);
      step();
    end
    or0 = 1'b1;
    recv(0, s0, p + 5, s0.len());

    // New word offered while busy
    send(0, 64'h0123456789abcdef);
    iv0 = 1'b1;
    id0 = 64'h00000000deadbeef;
    chk("busy_ready_lo", ir0, 0);
    recv(0, s0, 0, 8);
    chk("busy_ready_mid", ir0, 0);
    recv(0, s0, 8, s0.len());
    chk("gap_ready", ir0, 1);
    chk("gap_valid", ov0, 0);
    step();
    iv0 = 1'b0;
    recv(0, sb, 0, sb.len());

    // Reset asserted during the 9th byte
    send(0, 64'h0123456789abcdef);
    recv(0, s0, 0, 8);
    chk("pre_rst_valid", ov0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", ov0, 0);
    chk("async_busy", bz0, 0);
    chk("async_char", oc0, 8'h00);
    chk("async_ready", ir0, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", ir0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_quiet", ov0, 0);
      step();
    end

    // Recovery after reset
    send(0, 64'h00000000deadbeef);
    recv(0, sb, 0, sb.len());
    chk("final_busy", bz0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
